// File: rtl/p2b_counter_if.sv
// Handshake bundle for the pulse-to-binary counter.
// The master modport is the counter's side; the slave modport is the stream source and result consumer.
interface p2b_counter_if;
    logic        pulsed_in;
    logic        enable;
    logic        start;
    logic        out_ready;
    logic [15:0] binary_out;
    logic        out_valid;
    logic        busy;

    modport master (
        input  pulsed_in, enable, start, out_ready,
        output binary_out, out_valid, busy
    );

    modport slave (
        output pulsed_in, enable, start, out_ready,
        input  binary_out, out_valid, busy
    );
endinterface

// File: rtl/p2b_counter.sv
// Pulse-to-binary stochastic converter: counts 1s over a window of 2^WINDOW_LOG2 enabled
// samples and presents a 16-bit probability estimate (value/65536) through valid/ready.
module p2b_counter #(
    parameter int WINDOW_LOG2 = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    p2b_counter_if.master bus
);
    localparam int CNT_W = WINDOW_LOG2 + 1;
    localparam int SHIFT = 16 - WINDOW_LOG2;
    localparam logic [CNT_W-1:0] FULL = {1'b1, {WINDOW_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       ones_cnt;
    logic [WINDOW_LOG2-1:0] sample_cnt;
    logic [15:0]            result;
    logic                   valid;
    logic                   busy;
    logic [CNT_W-1:0]       ones_next;
    logic                   last_sample;

    // A window of all 1s would overflow the 16-bit scale, so it pins to full scale.
    function automatic logic [15:0] scale_result(input logic [CNT_W-1:0] ones);
        if (ones == FULL) begin
            return 16'hFFFF;
        end
        return 16'(32'(ones) << SHIFT);
    endfunction

    always_comb begin
        ones_next   = ones_cnt + CNT_W'(bus.pulsed_in);
        last_sample = (sample_cnt == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ones_cnt   <= '0;
            sample_cnt <= '0;
            result     <= 16'h0000;
            valid      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ones_cnt   <= '0;
                        sample_cnt <= '0;
                        busy       <= 1'b1;
                        state      <= COUNT;
                    end
                end
                COUNT: begin
                    if (bus.enable) begin
                        ones_cnt   <= ones_next;
                        sample_cnt <= sample_cnt + 1'b1;
                        if (last_sample) begin
                            result <= scale_result(ones_next);
                            valid  <= 1'b1;
                            busy   <= 1'b0;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    // start only counts when the result is consumed on the same edge.
                    if (bus.out_ready) begin
                        valid <= 1'b0;
                        if (bus.start) begin
                            ones_cnt   <= '0;
                            sample_cnt <= '0;
                            busy       <= 1'b1;
                            state      <= COUNT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.binary_out = result;
    assign bus.out_valid  = valid;
    assign bus.busy       = busy;
endmodule
